// File: rtl/dadd_sched_pkg.sv
// ============================================================================
// Module : dadd_sched_pkg
// Brief  : Shared types and default sizes for the dADD job scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dadd_sched_pkg;

    localparam int c_LOGINUM = 3;
    localparam int c_BSW     = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        WARM = 3'd2,
        RUN  = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/dadd_job_sched_counter.sv
// ============================================================================
// Module : bit_ones_counter
// Brief  : Serial ones accumulator with synchronous clear and enable.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bit_ones_counter
    import dadd_sched_pkg::*;
#(
    parameter int BSW = c_BSW
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_clr,
    input  logic           i_en,
    input  logic           i_bit,
    output logic [BSW-1:0] o_count
);

    logic [BSW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + {{(BSW-1){1'b0}}, i_bit};
        end
    end

    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/dadd_job_sched.sv
// ============================================================================
// Module : dadd_job_sched
// Brief  : Runs one dADD adder evaluation job (reset, seed, count ones).
//          Optional DADD_SEED_AUTO_EN: internal rotating seed replaces req_seed.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dadd_job_sched
    import dadd_sched_pkg::*;
#(
    parameter int LOGINUM = c_LOGINUM,
    parameter int BSW     = c_BSW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [LOGINUM-1:0] req_seed,
    input  logic [BSW-1:0]     req_len,
    output logic               add_rst_n,
    output logic               add_load,
    output logic [LOGINUM-1:0] add_seed,
    input  logic               add_out,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [BSW-1:0]     res_ones,
    output logic               busy
);

    state_t             r_state;
    state_t             w_next;
    logic [LOGINUM-1:0] r_seed_q;
    logic [BSW-1:0]     r_len_q;
    logic [BSW-1:0]     r_down;
    logic [LOGINUM-1:0] w_seed_src;
    logic               w_accept;
    logic               w_last;

    assign w_accept = req_valid && (r_state == IDLE);
    assign w_last   = (r_down == {{(BSW-1){1'b0}}, 1'b1});

`ifdef DADD_SEED_AUTO_EN
    logic [LOGINUM-1:0] r_auto_seed;
    logic               w_unused_seed;

    assign w_unused_seed = ^req_seed;
    assign w_seed_src    = r_auto_seed;

    // Rotates 1..2^LOGINUM-1, never producing the LFSR lock-up value 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_auto_seed <= {{(LOGINUM-1){1'b0}}, 1'b1};
        end else if (w_accept) begin
            if (r_auto_seed == {LOGINUM{1'b1}}) begin
                r_auto_seed <= {{(LOGINUM-1){1'b0}}, 1'b1};
            end else begin
                r_auto_seed <= r_auto_seed + {{(LOGINUM-1){1'b0}}, 1'b1};
            end
        end
    end
`else
    assign w_seed_src = req_seed;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_seed_q <= '0;
            r_len_q  <= '0;
            r_down   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_seed_q <= w_seed_src;
                r_len_q  <= req_len;
            end
            if (r_state == WARM) begin
                r_down <= r_len_q;
            end else if (r_state == RUN) begin
                r_down <= r_down - {{(BSW-1){1'b0}}, 1'b1};
            end
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = (req_len == '0) ? DONE : LOAD;
                end
            end
            LOAD: w_next = WARM;
            // Adder output is registered: the first valid bit arrives after WARM.
            WARM: w_next = RUN;
            RUN: begin
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    bit_ones_counter #(
        .BSW (BSW)
    ) u_ones (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_accept),
        .i_en    (r_state == RUN),
        .i_bit   (add_out),
        .o_count (res_ones)
    );

    assign req_ready = (r_state == IDLE);
    assign res_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign add_load  = (r_state == LOAD);
    assign add_seed  = r_seed_q;
    assign add_rst_n = rst_n && (r_state != LOAD);

endmodule

`default_nettype wire

// File: doc/dadd_job_sched.md
Name: dadd_job_sched

Overview:
- Job controller for the rotating-LFSR mux adder (dADD family).
- Accepts one evaluation job at a time over a valid/ready request port.
- Per job: resets the adder's Sobol select generator, seeds its LFSR and runs it for a requested number of bitstream cycles.
- Counts ones on the adder's serial output and returns the count over a valid/ready result port.
- Sits between the system-level test/accumulate logic and one adder instance.

Parameters:
- LOGINUM, 3, select/seed width; must equal the adder's LFSR width.
- BSW, 8, width of the job-length field and the ones count; max job length is 2^BSW-1 cycles.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low
- req_valid  in  1  job request present
- req_ready  out  1  scheduler can accept a job
- req_seed  in  LOGINUM  LFSR seed for the job
- req_len  in  BSW  number of output bits to accumulate
- add_rst_n  out  1  reset to the adder instance, active-low
- add_load  out  1  drives the adder's seed-load input
- add_seed  out  LOGINUM  drives the adder's seed-data input
- add_out  in  1  adder serial output (registered inside the adder)
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_ones  out  BSW  ones counted
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset is synchronous: when rst_n=0 at a clk edge, the next state is IDLE regardless of current state, including mid-RUN.
- Reset values:
  - req_ready=1, res_valid=0, res_ones=0, busy=0
  - add_load=0, add_seed=0
  - add_rst_n=0 while rst_n=0
- add_rst_n = rst_n AND (state != LOAD).
- FSM states: IDLE, LOAD, WARM, RUN, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: capture req_seed into seed_q and req_len into len_q, clear the ones counter.
  - If req_len=0, go to DONE with res_ones=0. Otherwise go to LOAD.
- LOAD (1 cycle):
  - add_load=1, add_seed=seed_q, add_rst_n=0, so the Sobol generator restarts.
  - Next state: WARM.
- WARM (1 cycle):
  - Covers the adder's 1-cycle registered output latency.
  - add_out is ignored.
  - Down-counter is loaded with len_q.
  - Next state: RUN.
- RUN:
  - Each cycle: ones += add_out, down-counter -= 1.
  - When the counter reaches 1 and that cycle's bit has been added, go to DONE.
  - Exactly len_q samples are taken.
- DONE:
  - res_valid=1; res_ones holds the count stable until res_valid&res_ready.
  - On handshake go to IDLE. req_ready only rises in the cycle after the handshake, so there is no back-to-back accept.
- The ones count cannot overflow (len ≤ 2^BSW-1); no saturation logic.
- add_seed holds seed_q outside LOAD.
- A request arriving while not IDLE is not accepted (req_ready=0).
- A seed of 0 is passed through unmodified; avoiding it is the requester's responsibility.

Optional Feature:
- Macro DADD_SEED_AUTO_EN.
- Defined:
  - req_seed is ignored.
  - An internal seed register (reset value 1) supplies seed_q.
  - It increments after each accepted job, wrapping 2^LOGINUM-1 → 1 and skipping 0, giving automatic per-job LFSR rotation.
- Undefined:
  - seed_q is taken from req_seed; no seed register exists.

Decomposition:
- Package dadd_sched_pkg holds:
  - enum state_t {IDLE, LOAD, WARM, RUN, DONE}
  - default LOGINUM/BSW constants
- Sub-module bit_ones_counter (BSW wide):
  - sync clear, enable, serial input, count output.
  - Instantiated once for the ones accumulator.

Test Plan:
- Reset then idle: rst_n low 3 cycles → req_ready=1, res_valid=0, add_rst_n=0, busy=0.
- Basic job: seed=5, len=8, stub add_out pattern 1,0,1,1,0,0,1,0 starting in the RUN cycle after WARM → LOAD pulse with add_seed=5 and add_rst_n=0; res_valid asserted 11 cycles after accept; res_ones=4.
- Zero length: len=0 → add_load never asserted; res_valid next cycle with res_ones=0.
- Backpressure: res_ready held 0 for 20 cycles after a len=255 job with add_out=1 → res_ones=255 stable, req_ready=0 throughout; accepts a new job only after the handshake.
- Mid-run reset: rst_n=0 at RUN cycle 50 of len=100 → next cycle IDLE, count cleared; a following len=4 job with all-ones input gives res_ones=4.
- DADD_SEED_AUTO_EN: 8 consecutive jobs → add_seed sequence 1,2,3,4,5,6,7,1.
